// File: rtl/mmio_bus_router.sv
// rtl/mmio_bus_router.sv - MEM-stage router steering loads/stores to DMEM or strobe/ack peripheral channels.
// Optional WAIT-state abort timer enabled by defining MMIO_TIMEOUT_EN.
module mmio_bus_router #(
    parameter int                     N_CH       = 4,
    parameter int                     ADDR_W     = 13,
    parameter logic [N_CH*ADDR_W-1:0] BASE_ADDRS = {13'h1010, 13'h100C, 13'h1008, 13'h1004},
    parameter int                     TIMEOUT    = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr,
    input  logic               we,
    input  logic               re,
    input  logic [31:0]        wdata,
    output logic               dmem_we,
    output logic               dmem_re,
    input  logic [31:0]        dmem_rdata,
    output logic [N_CH-1:0]    ch_we,
    output logic [N_CH-1:0]    ch_re,
    output logic [31:0]        ch_wdata,
    input  logic [N_CH-1:0]    ch_ack,
    input  logic [N_CH*32-1:0] ch_rdata,
    output logic [31:0]        rdata,
    output logic               stall,
    output logic               err
);

    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic              hit_any;
    logic [SEL_W-1:0]  hit_idx;
    logic [N_CH-1:0]   hit_onehot;
    logic [SEL_W-1:0]  sel;
    logic              op_wr;
    logic [31:0]       rdata_q;
    logic [31:0]       sel_rdata;
    logic              ack_sel;
    logic              expire;
    logic              start;
    logic              finish;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_W];

    // Lowest-numbered matching channel wins, so scan downwards and let lower i overwrite.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (addr[ADDR_W-1:0] == BASE_ADDRS[i*ADDR_W +: ADDR_W]) begin
                hit_any = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
        hit_onehot = N_CH'(1) << hit_idx;
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i)) sel_rdata = ch_rdata[i*32 +: 32];
        end
    end

    assign ack_sel = ch_ack[sel];
    assign start   = (state == IDLE) && (we || re) && hit_any;
    assign finish  = (state == WAIT) && (ack_sel || expire);

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // A same-cycle ack takes priority over expiry.
    assign expire = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !ack_sel;
    assign err    = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= finish && !ack_sel;
            if (start) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT);
    assign expire         = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = WAIT;
            WAIT:    if (finish) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            op_wr    <= 1'b0;
            ch_wdata <= '0;
            ch_we    <= '0;
            ch_re    <= '0;
            rdata_q  <= '0;
        end else begin
            if (start) begin
                sel      <= hit_idx;
                op_wr    <= we;
                ch_wdata <= wdata;
                ch_we    <= we ? hit_onehot : '0;
                ch_re    <= we ? '0 : hit_onehot;
            end
            if (finish) begin
                ch_we <= '0;
                ch_re <= '0;
                if (!op_wr) rdata_q <= ack_sel ? sel_rdata : 32'hDEAD_BEEF;
            end
        end
    end

    // Stall is gated by reset so an aborted access releases the pipeline immediately.
    always_comb begin
        stall   = !rst && (start || (state == WAIT));
        dmem_we = we && !hit_any;
        dmem_re = re && !we && !hit_any;
        rdata   = (state == IDLE) ? dmem_rdata : rdata_q;
    end

endmodule
